// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the core load/store path and an external master.
// Build option: define DMEM_ARB_RR_EN for round-robin tie-break; default is fixed core priority.
module dmem_arbiter #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned MTYPE_W     = 3,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               core_req,
    input  logic               core_we,
    input  logic [MTYPE_W-1:0] core_type,
    input  logic [DATA_W-1:0]  core_addr,
    input  logic [DATA_W-1:0]  core_wdata,
    output logic               core_gnt,
    output logic               core_rvalid,
    output logic [DATA_W-1:0]  core_rdata,
    output logic               core_stall,
    input  logic               ext_req,
    input  logic               ext_we,
    input  logic [MTYPE_W-1:0] ext_type,
    input  logic [DATA_W-1:0]  ext_addr,
    input  logic [DATA_W-1:0]  ext_wdata,
    output logic               ext_gnt,
    output logic               ext_rvalid,
    output logic [DATA_W-1:0]  ext_rdata,
    output logic               mem_en,
    output logic               mem_we,
    output logic [MTYPE_W-1:0] mem_type,
    output logic [DATA_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata
);

    localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} stateT;

    typedef struct packed {
        logic               isExt;
        logic               we;
        logic [MTYPE_W-1:0] mtype;
        logic [DATA_W-1:0]  addr;
        logic [DATA_W-1:0]  wdata;
    } cmdT;

    stateT           state;
    stateT           stateNext;
    cmdT             cmd;
    logic [CNT_W-1:0] cnt;
    logic            anyReq;
    logic            winExt;
    logic            startTxn;

    assign anyReq   = core_req | ext_req;
    assign startTxn = (state == StIdle) & anyReq;

`ifdef DMEM_ARB_RR_EN
    // Remembers who won last so a tie goes to the other requester; reset favours the core.
    logic lastExt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lastExt <= 1'b1;
        end else if (startTxn) begin
            lastExt <= winExt;
        end
    end

    assign winExt = ext_req & (~core_req | ~lastExt);
`else
    assign winExt = ext_req & ~core_req;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= StIdle;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            StIdle:  if (anyReq) stateNext = StIssue;
            StIssue: stateNext = StWait;
            StWait:  if (cnt == '0) stateNext = StResp;
            StResp:  stateNext = StIdle;
            default: stateNext = StIdle;
        endcase
    end

    // Command latch, latency counter and per-requester load data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd        <= '0;
            cnt        <= '0;
            core_rdata <= '0;
            ext_rdata  <= '0;
        end else begin
            if (startTxn) begin
                cmd.isExt <= winExt;
                cmd.we    <= winExt ? ext_we    : core_we;
                cmd.mtype <= winExt ? ext_type  : core_type;
                cmd.addr  <= winExt ? ext_addr  : core_addr;
                cmd.wdata <= winExt ? ext_wdata : core_wdata;
            end
            if (state == StIssue) begin
                cnt <= CNT_W'(MEM_LATENCY - 1);
            end else if ((state == StWait) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            if ((state == StWait) && (cnt == '0) && !cmd.we) begin
                if (cmd.isExt) begin
                    ext_rdata <= mem_rdata;
                end else begin
                    core_rdata <= mem_rdata;
                end
            end
        end
    end

    // Moore outputs decoded from the state and command registers
    always_comb begin
        core_gnt    = 1'b0;
        ext_gnt     = 1'b0;
        core_rvalid = 1'b0;
        ext_rvalid  = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_type    = '0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (state)
            StIssue: begin
                mem_en    = 1'b1;
                mem_we    = cmd.we;
                mem_type  = cmd.mtype;
                mem_addr  = cmd.addr;
                mem_wdata = cmd.wdata;
                core_gnt  = ~cmd.isExt;
                ext_gnt   = cmd.isExt;
            end
            StResp: begin
                core_rvalid = ~cmd.isExt;
                ext_rvalid  = cmd.isExt;
            end
            default: ;
        endcase
    end

    assign core_stall = core_req & ~core_rvalid;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance at latency 1, one at latency 4.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset;

    logic        core_req, core_we, ext_req, ext_we;
    logic [2:0]  core_type, ext_type;
    logic [63:0] core_addr, core_wdata, ext_addr, ext_wdata, mem_rdata;
    logic        core_gnt, core_rvalid, core_stall, ext_gnt, ext_rvalid;
    logic        mem_en, mem_we;
    logic [2:0]  mem_type;
    logic [63:0] core_rdata, ext_rdata, mem_addr, mem_wdata;

    logic        b_core_req, b_core_we, b_ext_req, b_ext_we;
    logic [2:0]  b_core_type, b_ext_type;
    logic [63:0] b_core_addr, b_core_wdata, b_ext_addr, b_ext_wdata, b_mem_rdata;
    logic        b_core_gnt, b_core_rvalid, b_core_stall, b_ext_gnt, b_ext_rvalid;
    logic        b_mem_en, b_mem_we;
    logic [2:0]  b_mem_type;
    logic [63:0] b_core_rdata, b_ext_rdata, b_mem_addr, b_mem_wdata;

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(64), .MTYPE_W(3), .MEM_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_type(core_type),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .core_stall(core_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_type(ext_type),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_type(mem_type),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.DATA_W(64), .MTYPE_W(3), .MEM_LATENCY(4)) dut4 (
        .clk(clk), .reset(reset),
        .core_req(b_core_req), .core_we(b_core_we), .core_type(b_core_type),
        .core_addr(b_core_addr), .core_wdata(b_core_wdata),
        .core_gnt(b_core_gnt), .core_rvalid(b_core_rvalid), .core_rdata(b_core_rdata),
        .core_stall(b_core_stall),
        .ext_req(b_ext_req), .ext_we(b_ext_we), .ext_type(b_ext_type),
        .ext_addr(b_ext_addr), .ext_wdata(b_ext_wdata),
        .ext_gnt(b_ext_gnt), .ext_rvalid(b_ext_rvalid), .ext_rdata(b_ext_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_type(b_mem_type),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic expCore, expExt, expCoreRv, expExtRv, rr;
        int   k;
`ifdef DMEM_ARB_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        reset = 1'b0;
        core_req = 0; core_we = 0; core_type = 0; core_addr = 0; core_wdata = 0;
        ext_req = 0; ext_we = 0; ext_type = 0; ext_addr = 0; ext_wdata = 0;
        mem_rdata = 0;
        b_core_req = 0; b_core_we = 0; b_core_type = 0; b_core_addr = 0; b_core_wdata = 0;
        b_ext_req = 0; b_ext_we = 0; b_ext_type = 0; b_ext_addr = 0; b_ext_wdata = 0;
        b_mem_rdata = 0;

        // Reset state
        tick(); tick();
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_core_gnt", 64'(core_gnt), 64'd0);
        chk("rst_core_rvalid", 64'(core_rvalid), 64'd0);
        chk("rst_core_rdata", core_rdata, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);

        // Core load 0x100 returning 0xDEADBEEF
        reset = 1'b1;
        core_req = 1; core_we = 0; core_type = 3'd3; core_addr = 64'h100;
        #1;
        chk("ld_c0_stall", 64'(core_stall), 64'd1);
        chk("ld_c0_gnt", 64'(core_gnt), 64'd0);
        tick();
        chk("ld_c1_gnt", 64'(core_gnt), 64'd1);
        chk("ld_c1_mem_en", 64'(mem_en), 64'd1);
        chk("ld_c1_mem_addr", mem_addr, 64'h100);
        chk("ld_c1_mem_we", 64'(mem_we), 64'd0);
        chk("ld_c1_ext_gnt", 64'(ext_gnt), 64'd0);
        chk("ld_c1_stall", 64'(core_stall), 64'd1);
        mem_rdata = 64'hDEAD_BEEF;
        tick();
        chk("ld_c2_gnt", 64'(core_gnt), 64'd0);
        chk("ld_c2_mem_en", 64'(mem_en), 64'd0);
        chk("ld_c2_mem_addr", mem_addr, 64'd0);
        chk("ld_c2_rvalid", 64'(core_rvalid), 64'd0);
        chk("ld_c2_stall", 64'(core_stall), 64'd1);
        tick();
        mem_rdata = 64'hBAD;
        chk("ld_c3_rvalid", 64'(core_rvalid), 64'd1);
        chk("ld_c3_rdata", core_rdata, 64'hDEAD_BEEF);
        chk("ld_c3_stall", 64'(core_stall), 64'd0);
        core_req = 0;
        tick();
        chk("ld_c4_rvalid", 64'(core_rvalid), 64'd0);
        chk("ld_c4_rdata_hold", core_rdata, 64'hDEAD_BEEF);

        // Core store SD 0x55 -> 0x20
        core_req = 1; core_we = 1; core_type = 3'd3; core_addr = 64'h20; core_wdata = 64'h55;
        tick();
        chk("st_c1_mem_en", 64'(mem_en), 64'd1);
        chk("st_c1_mem_we", 64'(mem_we), 64'd1);
        chk("st_c1_mem_addr", mem_addr, 64'h20);
        chk("st_c1_mem_wdata", mem_wdata, 64'h55);
        chk("st_c1_mem_type", 64'(mem_type), 64'd3);
        chk("st_c1_gnt", 64'(core_gnt), 64'd1);
        mem_rdata = 64'h1234;
        tick();
        chk("st_c2_mem_en", 64'(mem_en), 64'd0);
        chk("st_c2_mem_we", 64'(mem_we), 64'd0);
        tick();
        chk("st_c3_rvalid", 64'(core_rvalid), 64'd1);
        chk("st_c3_rdata_kept", core_rdata, 64'hDEAD_BEEF);
        core_req = 0; core_we = 0;

        // Reset asserted while a core load is in WAIT
        tick();
        chk("rw_idle_rvalid", 64'(core_rvalid), 64'd0);
        core_req = 1; core_addr = 64'h600; mem_rdata = 64'h999;
        tick();
        chk("rw_issue_mem_en", 64'(mem_en), 64'd1);
        tick();
        reset = 1'b0;
        core_req = 0;
        #1;
        chk("rw_mem_en", 64'(mem_en), 64'd0);
        chk("rw_core_gnt", 64'(core_gnt), 64'd0);
        chk("rw_core_rvalid", 64'(core_rvalid), 64'd0);
        chk("rw_core_rdata", core_rdata, 64'd0);
        chk("rw_core_stall", 64'(core_stall), 64'd0);
        tick();
        chk("rw_hold_rvalid", 64'(core_rvalid), 64'd0);
        chk("rw_hold_mem_en", 64'(mem_en), 64'd0);

        // Both requesting continuously after reset release
        reset = 1'b1;
        mem_rdata = 64'hA5;
        core_req = 1; ext_req = 1; core_addr = 64'h300; ext_addr = 64'h400;
        for (int c = 1; c <= 16; c++) begin
            tick();
            k = (c - 1) / 4;
            expExt    = rr && (k % 2 == 1);
            expCore   = (c % 4 == 1) && !expExt;
            expCoreRv = (c % 4 == 3) && !expExt;
            expExtRv  = (c % 4 == 3) && expExt;
            expExt    = (c % 4 == 1) && expExt;
            chk($sformatf("both_c%0d_core_gnt", c), 64'(core_gnt), 64'(expCore));
            chk($sformatf("both_c%0d_ext_gnt", c), 64'(ext_gnt), 64'(expExt));
            chk($sformatf("both_c%0d_core_rvalid", c), 64'(core_rvalid), 64'(expCoreRv));
            chk($sformatf("both_c%0d_ext_rvalid", c), 64'(ext_rvalid), 64'(expExtRv));
        end
        chk("both_core_rdata", core_rdata, 64'hA5);
        chk("both_ext_rdata", ext_rdata, rr ? 64'hA5 : 64'd0);
        core_req = 0; ext_req = 0;

        // External load whose request drops right after being sampled
        tick();
        ext_req = 1; ext_we = 0; ext_addr = 64'h500; mem_rdata = 64'h77;
        tick();
        chk("xd_c1_ext_gnt", 64'(ext_gnt), 64'd1);
        chk("xd_c1_mem_en", 64'(mem_en), 64'd1);
        chk("xd_c1_mem_addr", mem_addr, 64'h500);
        chk("xd_c1_core_gnt", 64'(core_gnt), 64'd0);
        ext_req = 0;
        for (int c = 2; c <= 6; c++) begin
            tick();
            chk($sformatf("xd_c%0d_ext_gnt", c), 64'(ext_gnt), 64'd0);
            chk($sformatf("xd_c%0d_mem_en", c), 64'(mem_en), 64'd0);
            chk($sformatf("xd_c%0d_ext_rvalid", c), 64'(ext_rvalid), 64'(c == 3));
        end
        chk("xd_ext_rdata", ext_rdata, 64'h77);
        chk("xd_core_rdata_kept", core_rdata, 64'hA5);

        // Latency-4 instance: external load
        b_ext_req = 1; b_ext_addr = 64'h40; b_mem_rdata = 64'h111;
        tick();
        chk("l4_c1_ext_gnt", 64'(b_ext_gnt), 64'd1);
        chk("l4_c1_mem_en", 64'(b_mem_en), 64'd1);
        chk("l4_c1_mem_addr", b_mem_addr, 64'h40);
        b_ext_req = 0;
        for (int c = 2; c <= 5; c++) begin
            tick();
            if (c == 5) b_mem_rdata = 64'hCAFE;
            chk($sformatf("l4_c%0d_ext_rvalid", c), 64'(b_ext_rvalid), 64'd0);
            chk($sformatf("l4_c%0d_mem_en", c), 64'(b_mem_en), 64'd0);
        end
        tick();
        b_mem_rdata = 64'h111;
        chk("l4_c6_ext_rvalid", 64'(b_ext_rvalid), 64'd1);
        chk("l4_c6_ext_rdata", b_ext_rdata, 64'hCAFE);
        tick();
        chk("l4_c7_ext_rvalid", 64'(b_ext_rvalid), 64'd0);
        chk("l4_c7_ext_rdata", b_ext_rdata, 64'hCAFE);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
